// File: rtl/serial_out_tx.sv
// Serial-output transmitter: shifts one WIDTH-bit word out MSB- or LSB-first,
// holding each bit at least DIV clocks and waiting on the receiver's so_ready.
module serial_out_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             abort,
  input  logic             so_ready,
  output logic             ready,
  output logic             so_frame,
  output logic             so_valid,
  output logic             so_data,
  output logic             done,
  output logic             load_err
);

  // Handshake: a bit transfers on any cycle where so_valid && so_ready are both
  // high; so_valid never drops and so_data never changes until that happens.

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             msb_q, msb_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             load_err_q, load_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      msb_q      <= 1'b0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      msb_q      <= msb_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    msb_d      = msb_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    load_err_d = 1'b0;
    ready      = 1'b0;
    so_frame   = 1'b0;
    so_valid   = 1'b0;
    so_data    = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load_en) begin
          sr_d      = data_in;
          msb_d     = msb_first;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        so_frame   = 1'b1;
        so_data    = msb_q ? sr_q[WIDTH-1] : sr_q[0];
        so_valid   = (div_cnt_q == DIV_MAX);
        load_err_d = load_en;
        // Abort wins over a transfer landing in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (so_valid && so_ready) begin
          sr_d      = msb_q ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_DONE;
          end
        end else if (!so_valid) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        load_err_d = load_en;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_serial_out_tx.sv
// Bench for serial_out_tx: one DIV=1 and one DIV=4 instance, directed and
// randomized frames checked against a per-bit timing model and a bit queue.
module tb_serial_out_tx;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         load_en   [2];
  logic [W-1:0] data_in   [2];
  logic         msb_first [2];
  logic         abort     [2];
  logic         so_ready  [2];
  logic         ready     [2];
  logic         so_frame  [2];
  logic         so_valid  [2];
  logic         so_data   [2];
  logic         done      [2];
  logic         load_err  [2];

  logic exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_out_tx #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_en(load_en[0]), .data_in(data_in[0]),
    .msb_first(msb_first[0]), .abort(abort[0]), .so_ready(so_ready[0]),
    .ready(ready[0]), .so_frame(so_frame[0]), .so_valid(so_valid[0]),
    .so_data(so_data[0]), .done(done[0]), .load_err(load_err[0])
  );

  serial_out_tx #(.WIDTH(W), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .load_en(load_en[1]), .data_in(data_in[1]),
    .msb_first(msb_first[1]), .abort(abort[1]), .so_ready(so_ready[1]),
    .ready(ready[1]), .so_frame(so_frame[1]), .so_valid(so_valid[1]),
    .so_data(so_data[1]), .done(done[1]), .load_err(load_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag, input logic exp_err);
    check({tag, "_ready"},    ready[d],    1'b1);
    check({tag, "_frame"},    so_frame[d], 1'b0);
    check({tag, "_valid"},    so_valid[d], 1'b0);
    check({tag, "_data"},     so_data[d],  1'b0);
    check({tag, "_done"},     done[d],     1'b0);
    check({tag, "_load_err"}, load_err[d], exp_err);
  endtask

  // mode 0: so_ready always 1; 1: random so_ready; 2: stall 10 cycles on stall_bit.
  // Bit positions of -1 disable abort / mid-frame load injection.
  task automatic run_frame(input int d, input logic [W-1:0] word, input bit msb,
                           input int mode, input int stall_bit, input int abort_bit,
                           input int err_bit, input bit err_in_done, output int done_cyc);
    int div, k, held, cyc, stalled;
    bit exp_valid, rdy, aborted, err_pending;
    div = (d == 0) ? 1 : 4;
    k = 0; held = 0; cyc = 1; stalled = 0;
    aborted = 1'b0; err_pending = 1'b0;
    done_cyc = -1;
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(msb ? word[W-1-i] : word[i]);

    load_en[d] = 1'b1; data_in[d] = word; msb_first[d] = msb;
    next_cycle();
    load_en[d] = 1'b0; data_in[d] = W'($urandom); msb_first[d] = ~msb;

    while (k < W && !aborted && cyc < 1000) begin
      exp_valid = (held >= div - 1);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else begin
        rdy = 1'b1;
        if (k == stall_bit && exp_valid && stalled < 10) begin
          rdy = 1'b0;
          stalled++;
        end
      end
      check("shift_ready",    ready[d],    1'b0);
      check("shift_frame",    so_frame[d], 1'b1);
      check("shift_done",     done[d],     1'b0);
      check("shift_valid",    so_valid[d], exp_valid);
      check("shift_data",     so_data[d],  exp_q[0]);
      check("shift_load_err", load_err[d], err_pending);
      so_ready[d] = rdy;
      abort[d]    = (k == abort_bit && held == 0);
      load_en[d]  = (k == err_bit && held == 0);
      data_in[d]  = 16'hFFFF;
      err_pending = load_en[d];
      if (abort[d]) aborted = 1'b1;
      else if (exp_valid && rdy) begin
        void'(exp_q.pop_front());
        k++;
        held = 0;
      end else held++;
      next_cycle();
      cyc++;
      abort[d] = 1'b0; load_en[d] = 1'b0; so_ready[d] = 1'b1;
    end

    if (cyc >= 1000) begin
      n_tests++;
      n_fail++;
      $error("FAIL frame_timeout: observed bit %0d expected %0d", k, W);
    end else if (aborted) begin
      check_idle(d, "abort", err_pending);
    end else begin
      done_cyc = cyc;
      check("done_pulse", done[d],     1'b1);
      check("done_frame", so_frame[d], 1'b0);
      check("done_valid", so_valid[d], 1'b0);
      check("done_ready", ready[d],    1'b0);
      check("done_data",  so_data[d],  1'b0);
      check("done_err",   load_err[d], err_pending);
      check("bits_left",  exp_q.size(), 0);
      load_en[d] = err_in_done; data_in[d] = 16'hFFFF;
      next_cycle();
      load_en[d] = 1'b0;
      check_idle(d, "after_done", err_in_done);
    end
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 2; i++) begin
      load_en[i] = 1'b0; data_in[i] = '0; msb_first[i] = 1'b0;
      abort[i] = 1'b0; so_ready[i] = 1'b1;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    check_idle(0, "reset1", 1'b0);
    check_idle(1, "reset4", 1'b0);

    // DIV=1, 0xA5C3 MSB-first, then back-to-back 0x0001 LSB-first
    run_frame(0, 16'hA5C3, 1'b1, 0, -1, -1, -1, 1'b0, dc);
    check("t1_done_cycle", dc, 17);
    run_frame(0, 16'h0001, 1'b0, 0, -1, -1, -1, 1'b0, dc);
    check("t2_done_cycle", dc, 17);

    // DIV=4, 0x8000, receiver stalls 10 cycles on bit 3
    run_frame(1, 16'h8000, 1'b1, 2, 3, -1, -1, 1'b0, dc);
    check("t3_done_cycle", dc, 75);
    run_frame(1, 16'hC3A5, 1'b0, 0, -1, -1, -1, 1'b0, dc);
    check("div4_done_cycle", dc, 65);

    // Load during SHIFT and during DONE is dropped with load_err
    run_frame(0, 16'h1234, 1'b1, 0, -1, -1, 5, 1'b1, dc);
    check("t4_done_cycle", dc, 17);

    // Abort during bit 7, then a clean frame
    run_frame(0, 16'hBEEF, 1'b1, 0, -1, 7, -1, 1'b0, dc);
    run_frame(0, 16'h00FF, 1'b1, 0, -1, -1, -1, 1'b0, dc);
    check("t5_done_cycle", dc, 17);
    run_frame(1, 16'h7E81, 1'b0, 1, -1, 7, -1, 1'b0, dc);
    run_frame(1, 16'h00FF, 1'b0, 0, -1, -1, -1, 1'b0, dc);
    check("t5b_done_cycle", dc, 65);

    // Reset mid-frame
    load_en[0] = 1'b1; data_in[0] = 16'h5A5A; msb_first[0] = 1'b1;
    next_cycle();
    load_en[0] = 1'b0;
    repeat (5) next_cycle();
    check("rst_busy_frame", so_frame[0], 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_idle(0, "rst_mid", 1'b0);
    repeat (20) begin
      check("rst_no_done", done[0], 1'b0);
      check("rst_no_frame", so_frame[0], 1'b0);
      next_cycle();
    end
    run_frame(0, 16'h6C39, 1'b1, 0, -1, -1, -1, 1'b0, dc);
    check("t6_done_cycle", dc, 17);

    // Randomized frames with random back-pressure and occasional bad loads
    for (int n = 0; n < 12; n++) begin
      int d;
      int eb;
      d  = $urandom_range(0, 1);
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_frame(d, W'($urandom), 1'($urandom_range(0, 1)), 1, -1, -1, eb,
                1'($urandom_range(0, 1)), dc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
